alu_operand_stage: RTL and testbench
====================================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter WIDTH, 32, datapath width of operands and results.
REQ-002 Parameter IMM_WIDTH, 16, immediate field width; IMM_WIDTH <= WIDTH is a legal-configuration requirement.
REQ-003 Parameter CNT_WIDTH, 16, width of the issued-operation counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  upstream operand set valid.
REQ-007 in_ready  out  1  stage can accept an operand set this cycle.
REQ-008 alu_src  in  1  0 = register operand, 1 = extended immediate.
REQ-009 ext_mode  in  2  00 sign-extend, 01 zero-extend, 10 upper (imm in top IMM_WIDTH bits, low bits 0), 11 sign-extend.
REQ-010 fwd_sel  in  2  00 read_data2, 01 exmem_result, 10 memwb_result, 11 exmem_result.
REQ-011 read_data2  in  WIDTH  register-file second read port.
REQ-012 imm  in  IMM_WIDTH  raw immediate field.
REQ-013 exmem_result / memwb_result  in  WIDTH  forwarding sources.
REQ-014 flush  in  1  discard all held and incoming operand sets.
REQ-015 out_valid  out  1  result/store_data valid.
REQ-016 out_ready  in  1  downstream ALU accepts this cycle.
REQ-017 result  out  WIDTH  selected ALU operand B.
REQ-018 store_data  out  WIDTH  forwarded register operand (independent of alu_src).
REQ-019 op_count  out  CNT_WIDTH  number of completed output handshakes.

Function
REQ-020 Forwarded register value fwd = per fwd_sel; store_data SHALL always be fwd.
REQ-021 result SHALL be fwd when alu_src=0, extended imm per ext_mode when alu_src=1; forwarding never alters the immediate path.
REQ-022 Accept = in_valid && in_ready; output handshake = out_valid && out_ready.
REQ-023 Latency: set accepted at edge N into empty stage SHALL appear with out_valid=1 after edge N (1 cycle).
REQ-024 Storage: main output register plus one skid register; in_ready SHALL equal !skid_valid && rst_n (registered, no combinational path from out_ready).
REQ-025 Accept while main holds data not handshaken SHALL load skid; in_ready falls after that edge.
REQ-026 Main handshake with skid full SHALL move skid into main at same edge; skid_valid clears; simultaneous accept impossible (in_ready=0).
REQ-027 Main handshake with skid empty and simultaneous accept SHALL load new set directly into main; out_valid stays 1.
REQ-028 While out_valid=1 and out_ready=0, result and store_data SHALL remain stable.
REQ-029 Ordering SHALL be strictly FIFO; no set dropped or duplicated except by flush/reset.
REQ-030 flush SHALL clear main and skid valids at next edge; set presented with flush is discarded; flush overrides accept and handshake-driven moves; data registers may retain stale values.
REQ-031 A handshake in the flush cycle SHALL still count.
REQ-032 op_count SHALL increment by 1 per output handshake, wrap from all-ones to 0, unaffected by flush.

Reset
REQ-033 rst_n=0 at an edge SHALL set out_valid=0, skid_valid=0, result=0, store_data=0, op_count=0; in_ready=0 while rst_n=0, 1 on first cycle after release.
REQ-034 Reset mid-operation SHALL discard all held sets; inputs during reset are ignored.

Verification
REQ-035 alu_src=1, ext_mode=00, read_data2=0x0001_0000, imm=0x0110, one accept -> next cycle result=0x0000_0110, store_data=0x0001_0000, out_valid=1.
REQ-036 imm=0x8001, alu_src=1: ext_mode 00 -> 0xFFFF_8001; 01 -> 0x0000_8001; 10 -> 0x8001_0000.
REQ-037 alu_src=0, read_data2=0x11, exmem=0x22, memwb=0x33: fwd_sel 00/01/10/11 -> result 0x11/0x22/0x33/0x22.
REQ-038 out_ready=0, push A, B -> in_ready=0 after B; raise out_ready -> A then B on consecutive cycles, op_count +2, no loss.
REQ-039 Skid and main full, assert flush with in_valid=1 (C) -> next cycle out_valid=0, in_ready=1, C never appears.
REQ-040 Preload op_count to all-ones via 2^CNT_WIDTH-1 handshakes (CNT_WIDTH=4: 15), one more -> op_count=0; rst_n=0 mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// Purpose:
//   Selects ALU operand B and the store-data operand and registers them in a
//   two-entry elastic buffer (main output register plus one skid register).
//   The register operand is chosen from the register file or one of two
//   forwarding sources. Operand B is either that forwarded value or the
//   extended immediate. in_ready is registered, so there is no combinational
//   path from out_ready to in_ready.
//
// Ports:
//   clk           in   clock, all state updates on the rising edge
//   rst_n         in   synchronous active-low reset
//   in_valid      in   upstream operand set valid
//   in_ready      out  stage can accept an operand set this cycle
//   alu_src       in   0 = forwarded register operand, 1 = extended immediate
//   ext_mode      in   00/11 sign-extend, 01 zero-extend, 10 upper placement
//   fwd_sel       in   00 read_data2, 01/11 exmem_result, 10 memwb_result
//   read_data2    in   register-file second read port
//   imm           in   raw immediate field
//   exmem_result  in   forwarding source from EX/MEM
//   memwb_result  in   forwarding source from MEM/WB
//   flush         in   discard all held and incoming operand sets
//   out_valid     out  result/store_data valid
//   out_ready     in   downstream ALU accepts this cycle
//   result        out  selected ALU operand B
//   store_data    out  forwarded register operand
//   op_count      out  number of completed output handshakes (wraps)
//
// IMM_WIDTH must not exceed WIDTH.
// -----------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 alu_src,
  input  logic [1:0]           ext_mode,
  input  logic [1:0]           fwd_sel,
  input  logic [WIDTH-1:0]     read_data2,
  input  logic [IMM_WIDTH-1:0] imm,
  input  logic [WIDTH-1:0]     exmem_result,
  input  logic [WIDTH-1:0]     memwb_result,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic [WIDTH-1:0]     store_data,
  output logic [CNT_WIDTH-1:0] op_count
);

  // Operand selection (combinational, from the incoming set)
  logic [WIDTH-1:0] fwd_val;
  logic [WIDTH-1:0] ext_val;
  logic [WIDTH-1:0] operand_val;

  always_comb begin
    fwd_val = read_data2;
    case (fwd_sel)
      2'b01:   fwd_val = exmem_result;
      2'b10:   fwd_val = memwb_result;
      2'b11:   fwd_val = exmem_result;
      default: fwd_val = read_data2;
    endcase
  end

  // Size casts extend according to the signedness of the operand, so the
  // $signed form sign-extends and the plain form zero-extends. Written this
  // way it stays legal when IMM_WIDTH equals WIDTH.
  always_comb begin
    ext_val = '0;
    case (ext_mode)
      2'b01:   ext_val = WIDTH'(imm);
      2'b10:   ext_val = WIDTH'(imm) << (WIDTH - IMM_WIDTH);
      default: ext_val = WIDTH'($signed(imm));
    endcase
  end

  // The immediate path never sees the forwarding mux.
  assign operand_val = alu_src ? ext_val : fwd_val;

  // Buffer state
  logic                 main_valid_reg,  main_valid_next;
  logic [WIDTH-1:0]     main_result_reg, main_result_next;
  logic [WIDTH-1:0]     main_store_reg,  main_store_next;
  logic                 skid_valid_reg,  skid_valid_next;
  logic [WIDTH-1:0]     skid_result_reg, skid_result_next;
  logic [WIDTH-1:0]     skid_store_reg,  skid_store_next;
  logic [CNT_WIDTH-1:0] count_reg,       count_next;

  logic accept;
  logic handshake;

  assign in_ready  = !skid_valid_reg && rst_n;
  assign accept    = in_valid && in_ready;
  assign handshake = main_valid_reg && out_ready;

  always_comb begin
    main_valid_next  = main_valid_reg;
    main_result_next = main_result_reg;
    main_store_next  = main_store_reg;
    skid_valid_next  = skid_valid_reg;
    skid_result_next = skid_result_reg;
    skid_store_next  = skid_store_reg;
    count_next       = count_reg;

    // A handshake completed in a flush cycle still counts.
    if (handshake) begin
      count_next = count_reg + CNT_WIDTH'(1);
    end

    if (flush) begin
      // Data registers keep stale contents; only the valids matter.
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (main_valid_reg && !out_ready) begin
      // Main is stalled: a new set can only go to the skid register.
      // in_ready guarantees the skid is empty whenever accept is high.
      if (accept) begin
        skid_valid_next  = 1'b1;
        skid_result_next = operand_val;
        skid_store_next  = fwd_val;
      end
    end else if (skid_valid_reg) begin
      // Main drained this edge and the skid holds the older set: promote it.
      // accept is impossible here because in_ready is low.
      main_valid_next  = 1'b1;
      main_result_next = skid_result_reg;
      main_store_next  = skid_store_reg;
      skid_valid_next  = 1'b0;
    end else if (accept) begin
      // Main is empty or drains this edge: load the new set straight in.
      main_valid_next  = 1'b1;
      main_result_next = operand_val;
      main_store_next  = fwd_val;
    end else begin
      main_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_reg  <= 1'b0;
      main_result_reg <= '0;
      main_store_reg  <= '0;
      skid_valid_reg  <= 1'b0;
      skid_result_reg <= '0;
      skid_store_reg  <= '0;
      count_reg       <= '0;
    end else begin
      main_valid_reg  <= main_valid_next;
      main_result_reg <= main_result_next;
      main_store_reg  <= main_store_next;
      skid_valid_reg  <= skid_valid_next;
      skid_result_reg <= skid_result_next;
      skid_store_reg  <= skid_store_next;
      count_reg       <= count_next;
    end
  end

  assign out_valid  = main_valid_reg;
  assign result     = main_result_reg;
  assign store_data = main_store_reg;
  assign op_count   = count_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
//
// Directed bench for alu_operand_stage (WIDTH=32, IMM_WIDTH=16, CNT_WIDTH=4).
// A table of operand-selection vectors is streamed back to back, followed by
// hand-written sequences for stall/skid, flush, counter wrap and reset.
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;

  localparam int WIDTH     = 32;
  localparam int IMM_WIDTH = 16;
  localparam int CNT_WIDTH = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic                 alu_src;
  logic [1:0]           ext_mode;
  logic [1:0]           fwd_sel;
  logic [WIDTH-1:0]     read_data2;
  logic [IMM_WIDTH-1:0] imm;
  logic [WIDTH-1:0]     exmem_result;
  logic [WIDTH-1:0]     memwb_result;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic [WIDTH-1:0]     store_data;
  logic [CNT_WIDTH-1:0] op_count;

  alu_operand_stage #(
    .WIDTH     (WIDTH),
    .IMM_WIDTH (IMM_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_src      (alu_src),
    .ext_mode     (ext_mode),
    .fwd_sel      (fwd_sel),
    .read_data2   (read_data2),
    .imm          (imm),
    .exmem_result (exmem_result),
    .memwb_result (memwb_result),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .store_data   (store_data),
    .op_count     (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        alu_src;
    logic [1:0]  ext_mode;
    logic [1:0]  fwd_sel;
    logic [31:0] rd2;
    logic [15:0] imm;
    logic [31:0] exm;
    logic [31:0] mwb;
    logic [31:0] exp_result;
    logic [31:0] exp_store;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;
  logic [CNT_WIDTH-1:0] exp_count = '0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end else begin
      $display("ok   %s: 0x%08h", name, actual);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    alu_src      = v.alu_src;
    ext_mode     = v.ext_mode;
    fwd_sel      = v.fwd_sel;
    read_data2   = v.rd2;
    imm          = v.imm;
    exmem_result = v.exm;
    memwb_result = v.mwb;
  endtask

  // Register-path operand: result and store_data both equal read_data2.
  task automatic drive_reg(input logic [31:0] value);
    alu_src      = 1'b0;
    ext_mode     = 2'b00;
    fwd_sel      = 2'b00;
    read_data2   = value;
    imm          = 16'h0000;
    exmem_result = 32'h0;
    memwb_result = 32'h0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'b00, 2'b00, 32'h0001_0000, 16'h0110, 32'h0, 32'h0, 32'h0000_0110, 32'h0001_0000};
    vecs[1] = '{1'b1, 2'b00, 2'b01, 32'h11, 16'h8001, 32'h22, 32'h33, 32'hFFFF_8001, 32'h22};
    vecs[2] = '{1'b1, 2'b01, 2'b10, 32'h11, 16'h8001, 32'h22, 32'h33, 32'h0000_8001, 32'h33};
    vecs[3] = '{1'b1, 2'b10, 2'b11, 32'h11, 16'h8001, 32'h22, 32'h33, 32'h8001_0000, 32'h22};
    vecs[4] = '{1'b1, 2'b11, 2'b00, 32'h11, 16'h8001, 32'h22, 32'h33, 32'hFFFF_8001, 32'h11};
    vecs[5] = '{1'b0, 2'b00, 2'b00, 32'h11, 16'h8001, 32'h22, 32'h33, 32'h11, 32'h11};
    vecs[6] = '{1'b0, 2'b01, 2'b01, 32'h11, 16'h8001, 32'h22, 32'h33, 32'h22, 32'h22};
    vecs[7] = '{1'b0, 2'b10, 2'b10, 32'h11, 16'h8001, 32'h22, 32'h33, 32'h33, 32'h33};
    vecs[8] = '{1'b0, 2'b11, 2'b11, 32'h11, 16'h8001, 32'h22, 32'h33, 32'h22, 32'h22};
    vecs[9] = '{1'b1, 2'b00, 2'b00, 32'h11, 16'h7FFF, 32'h22, 32'h33, 32'h0000_7FFF, 32'h11};

    rst_n     = 1'b0;
    in_valid  = 1'b1;   // ignored during reset
    out_ready = 1'b1;
    flush     = 1'b0;
    drive_reg(32'hDEAD_BEEF);

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_store", store_data, 32'h0);
    check("rst_op_count", 32'(op_count), 32'h0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'h1);
    check("post_rst_out_valid", 32'(out_valid), 32'h0);

    // ---------------- table vectors, streamed back to back ----------------
    for (int i = 0; i < NVEC; i++) begin
      drive_vec(vecs[i]);
      in_valid = 1'b1;
      @(negedge clk);
      if (i > 0) exp_count++;  // previous vector handshaken on this edge
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'h1);
      check($sformatf("vec%0d_result", i), result, vecs[i].exp_result);
      check($sformatf("vec%0d_store", i), store_data, vecs[i].exp_store);
    end
    in_valid = 1'b0;
    @(negedge clk);
    exp_count++;
    check("vec_drain_out_valid", 32'(out_valid), 32'h0);
    check("vec_op_count", 32'(op_count), 32'(exp_count));

    // ---------------- stall: A into main, B into skid ----------------
    out_ready = 1'b0;
    drive_reg(32'hAAAA_0001);
    in_valid = 1'b1;
    @(negedge clk);
    check("stall_A_result", result, 32'hAAAA_0001);
    check("stall_A_in_ready", 32'(in_ready), 32'h1);
    drive_reg(32'hBBBB_0002);
    @(negedge clk);
    check("stall_B_in_ready", 32'(in_ready), 32'h0);
    check("stall_hold_result", result, 32'hAAAA_0001);
    in_valid = 1'b0;
    drive_reg(32'h5555_5555);
    @(negedge clk);
    check("stall_hold2_result", result, 32'hAAAA_0001);
    check("stall_hold2_store", store_data, 32'hAAAA_0001);
    check("stall_hold2_out_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    @(negedge clk);
    exp_count++;
    check("drain_B_result", result, 32'hBBBB_0002);
    check("drain_B_store", store_data, 32'hBBBB_0002);
    check("drain_B_out_valid", 32'(out_valid), 32'h1);
    check("drain_B_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    exp_count++;
    check("drain_done_out_valid", 32'(out_valid), 32'h0);
    check("drain_op_count", 32'(op_count), 32'(exp_count));

    // ---------------- flush with both registers full ----------------
    out_ready = 1'b0;
    drive_reg(32'hD000_000D);
    in_valid = 1'b1;
    @(negedge clk);
    drive_reg(32'hE000_000E);
    @(negedge clk);
    check("flush_pre_in_ready", 32'(in_ready), 32'h0);
    drive_reg(32'hC000_000C);
    flush     = 1'b1;
    out_ready = 1'b1;   // handshake of D in the flush cycle still counts
    @(negedge clk);
    exp_count++;
    check("flush_out_valid", 32'(out_valid), 32'h0);
    check("flush_in_ready", 32'(in_ready), 32'h1);
    check("flush_op_count", 32'(op_count), 32'(exp_count));
    // C presented again with in_ready=1: flush still discards it
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush2_out_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    check("flush_noC_out_valid", 32'(out_valid), 32'h0);
    check("flush_noC_op_count", 32'(op_count), 32'(exp_count));

    // ---------------- counter wrap ----------------
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive_reg(32'h0000_0100);
    @(negedge clk);
    drive_reg(32'h0000_0101);
    @(negedge clk);
    exp_count++;
    drive_reg(32'h0000_0102);
    @(negedge clk);
    exp_count++;
    in_valid = 1'b0;
    check("wrap_pre_op_count", 32'(op_count), 32'h0000_000F);
    check("wrap_pre_result", result, 32'h0000_0102);
    @(negedge clk);
    exp_count++;
    check("wrap_op_count", 32'(op_count), 32'h0);
    check("wrap_model_op_count", 32'(op_count), 32'(exp_count));

    // ---------------- reset mid-stream ----------------
    drive_reg(32'h0000_0777);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    exp_count++;
    check("prereset_op_count", 32'(op_count), 32'(exp_count));
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive_reg(32'h0000_0888);
    @(negedge clk);
    drive_reg(32'h0000_0999);
    @(negedge clk);
    check("prereset_skid_full", 32'(in_ready), 32'h0);
    rst_n = 1'b0;
    drive_reg(32'h0000_0AAA);
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_result", result, 32'h0);
    check("midrst_store", store_data, 32'h0);
    check("midrst_op_count", 32'(op_count), 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'h0);
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", 32'(in_ready), 32'h1);
    check("postrst_out_valid", 32'(out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
